scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder.sv | 97 +++++++++
 tb/tb_scan_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//   Registered index with a one-hot decoded output. The index either follows
//   the manual select input or steps automatically through 0..last, advancing
//   once every DIV enabled clock cycles.
//
// Parameters
//   SIZE_IN   index / select width (1..6)
//   SIZE_OUT  decoded output width, always 2**SIZE_IN
//   DIV       enabled clock cycles per scan step (>= 1)
//
// Ports
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   en    in   1 = run, 0 = freeze all state
//   mode  in   0 = manual (idx <= sel), 1 = scan (auto-step)
//   sel   in   manual-mode index
//   last  in   highest scan index
//   out   out  one-hot decode of idx (inverted when the macro below is set)
//   idx   out  registered current index
//   wrap  out  one-cycle pulse after a scan step from last (or above) to 0
//
// Build option
//   SCAN_DECODER_ACTIVE_LOW_EN  when defined, out is the bitwise inverse of
//                               the one-hot decode (only bit idx is 0).
// -----------------------------------------------------------------------------
module scan_decoder #(
  parameter int SIZE_IN  = 3,
  parameter int SIZE_OUT = 2**SIZE_IN,
  parameter int DIV      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [SIZE_IN-1:0]  sel,
  input  logic [SIZE_IN-1:0]  last,
  output logic [SIZE_OUT-1:0] out,
  output logic [SIZE_IN-1:0]  idx,
  output logic                wrap
);

  // A one-cycle-per-step divider (DIV = 1) still needs a 1-bit counter that
  // simply stays at 0, which makes tick permanently true.
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [SIZE_IN-1:0]  r_idx;
  logic [DIV_W-1:0]    r_div;
  logic                r_wrap;
  logic                w_tick;
  logic                w_at_end;
  logic [SIZE_OUT-1:0] w_onehot;

  assign w_tick   = (r_div == DIV_W'(DIV - 1));
  // ">=" rather than "==" so that lowering last below the current index
  // still wraps on the next tick instead of running up to the top.
  assign w_at_end = (r_idx >= last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_div  <= '0;
      r_wrap <= 1'b0;
    end else if (en) begin
      if (!mode) begin
        r_idx  <= sel;
        r_div  <= '0;
        r_wrap <= 1'b0;
      end else if (w_tick) begin
        r_div  <= '0;
        r_wrap <= w_at_end;
        r_idx  <= w_at_end ? '0 : r_idx + SIZE_IN'(1);
      end else begin
        r_div  <= r_div + DIV_W'(1);
        r_wrap <= 1'b0;
      end
    end else begin
      // Frozen: index and divider hold, but a pending wrap pulse must not
      // stretch across disabled cycles.
      r_wrap <= 1'b0;
    end
  end

  // Decoded from the index register only, so reset forces bit 0
  // immediately through the asynchronous clear of r_idx.
  assign w_onehot = {{(SIZE_OUT-1){1'b0}}, 1'b1} << r_idx;

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
  assign out = ~w_onehot;
`else
  assign out = w_onehot;
`endif

  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
//   Bench for scan_decoder. Two instances share the stimulus: the default
//   build (DIV = 4) and a DIV = 1 build. Each driven cycle pushes the
//   predicted outputs of both instances to a scoreboard queue; the entry is
//   popped and compared after the following rising edge. Directed phases add
//   checks against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_scan_decoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic [2:0] sel;
  logic [2:0] last;
  logic [7:0] out0, out1;
  logic [2:0] idx0, idx1;
  logic       wrap0, wrap1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] idx0;
    logic [7:0] out0;
    logic       wrap0;
    logic [2:0] idx1;
    logic [7:0] out1;
    logic       wrap1;
  } exp_t;

  exp_t sb_q[$];

  int   m_idx[2];
  int   m_cnt[2];
  logic m_wrap[2];

  scan_decoder #(.SIZE_IN(3), .DIV(4)) u_dut (
    .clk (clk), .rst (rst), .en (en), .mode (mode), .sel (sel), .last (last),
    .out (out0), .idx (idx0), .wrap (wrap0)
  );

  scan_decoder #(.SIZE_IN(3), .DIV(1)) u_dut1 (
    .clk (clk), .rst (rst), .en (en), .mode (mode), .sel (sel), .last (last),
    .out (out1), .idx (idx1), .wrap (wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_out(input logic [7:0] onehot);
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    return ~onehot;
`else
    return onehot;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k]  = 0;
      m_cnt[k]  = 0;
      m_wrap[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input int d);
    if (en) begin
      if (!mode) begin
        m_idx[k]  = int'(sel);
        m_cnt[k]  = 0;
        m_wrap[k] = 1'b0;
      end else if (m_cnt[k] == d - 1) begin
        m_cnt[k] = 0;
        if (m_idx[k] >= int'(last)) begin
          m_idx[k]  = 0;
          m_wrap[k] = 1'b1;
        end else begin
          m_idx[k]  = m_idx[k] + 1;
          m_wrap[k] = 1'b0;
        end
      end else begin
        m_cnt[k]  = m_cnt[k] + 1;
        m_wrap[k] = 1'b0;
      end
    end else begin
      m_wrap[k] = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus, predict, wait for the edge, compare.
  task automatic step(input logic e, input logic m, input logic [2:0] s,
                      input logic [2:0] l);
    exp_t x;
    en   = e;
    mode = m;
    sel  = s;
    last = l;
    model_step(0, 4);
    model_step(1, 1);
    x.idx0  = 3'(m_idx[0]);
    x.out0  = exp_out(8'b1 << m_idx[0]);
    x.wrap0 = m_wrap[0];
    x.idx1  = 3'(m_idx[1]);
    x.out1  = exp_out(8'b1 << m_idx[1]);
    x.wrap1 = m_wrap[1];
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb_q.pop_front();
      check_eq("sb_idx",   32'(idx0),  32'(x.idx0));
      check_eq("sb_out",   32'(out0),  32'(x.out0));
      check_eq("sb_wrap",  32'(wrap0), 32'(x.wrap0));
      check_eq("sb_idx1",  32'(idx1),  32'(x.idx1));
      check_eq("sb_out1",  32'(out1),  32'(x.out1));
      check_eq("sb_wrap1", 32'(wrap1), 32'(x.wrap1));
    end
  endtask

  initial begin
    int n;
    rst  = 1'b1;
    en   = 1'b0;
    mode = 1'b0;
    sel  = 3'd0;
    last = 3'd0;
    model_reset();

    // Reset state before any clock edge.
    #2;
    check_eq("rst_idx",  32'(idx0),  32'd0);
    check_eq("rst_out",  32'(out0),  32'(exp_out(8'h01)));
    check_eq("rst_wrap", 32'(wrap0), 32'd0);
    check_eq("rst_out1", 32'(out1),  32'(exp_out(8'h01)));

    @(posedge clk);
    #1;
    rst = 1'b0;

    // Manual decode.
    step(1'b1, 1'b0, 3'd5, 3'd0);
    check_eq("man_idx5", 32'(idx0), 32'd5);
    check_eq("man_out5", 32'(out0), 32'(exp_out(8'h20)));
    step(1'b1, 1'b0, 3'd7, 3'd0);
    check_eq("man_out7", 32'(out0), 32'(exp_out(8'h80)));
    step(1'b1, 1'b0, 3'd0, 3'd2);

    // Scan 0..2 with DIV = 4, including a 10-cycle freeze mid-step.
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (c >= 26 && c < 36) begin
        step(1'b0, 1'b1, 3'($urandom_range(0, 7)), 3'd2);
        check_eq("frz_wrap", 32'(wrap0), 32'd0);
      end else begin
        step(1'b1, 1'b1, 3'($urandom_range(0, 7)), 3'd2);
        n++;
        check_eq("scan_wrap", 32'(wrap0),
                 32'((n % 4 == 0) && ((n / 4) % 3 == 0)));
      end
      check_eq("scan_idx", 32'(idx0), 32'((n / 4) % 3));
    end

    // last lowered below the current index.
    step(1'b1, 1'b0, 3'd6, 3'd3);
    check_eq("low_idx6", 32'(idx0), 32'd6);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 3'd0, 3'd3);
    check_eq("low_hold", 32'(idx0), 32'd6);
    step(1'b1, 1'b1, 3'd0, 3'd3);
    check_eq("low_idx0", 32'(idx0), 32'd0);
    check_eq("low_wrap", 32'(wrap0), 32'd1);

    // DIV = 1 instance with last = 0: wrap on every cycle.
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b1, 3'd0, 3'd0);
      check_eq("div1_wrap", 32'(wrap1), 32'd1);
      check_eq("div1_idx",  32'(idx1),  32'd0);
    end

    // Asynchronous reset mid-scan at idx = 2.
    step(1'b1, 1'b0, 3'd0, 3'd5);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 3'd0, 3'd5);
    check_eq("pre_rst_idx", 32'(idx0), 32'd2);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_out",  32'(out0),  32'(exp_out(8'h01)));
    check_eq("arst_idx",  32'(idx0),  32'd0);
    check_eq("arst_wrap", 32'(wrap0), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 3'd0, 3'd5);
    check_eq("rel_hold", 32'(idx0), 32'd0);
    step(1'b1, 1'b1, 3'd0, 3'd5);
    check_eq("rel_step", 32'(idx0), 32'd1);

    // Random traffic, scoreboard only.
    for (int c = 0; c < 300; c++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) != 0),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
